chal_link_master: RTL and testbench
===================================

Name: chal_link_master

Overview:
- Host-side serial master for the challenge slave's cs/i/o bit-serial link.
- Generates the link clock from the system clock and shifts a 32-bit key into the slave, LSB first, with cs low.
- Pulses cs high for one link cycle to latch the key, then shifts in a 256-bit response, LSB first.
- Sits between on-chip control logic (start/done handshake) and the slave pins.

Parameters:
- KEY_W, 32, key bits shifted out per transaction.
- RESP_W, 256, response bits captured per transaction.
- HALF_PERIOD, 1, clk cycles per link_clk half-period (>=1); one link bit = 2*HALF_PERIOD clk cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- key  in  KEY_W  key value; captured on the accepting edge.
- busy  out  1  high from the accept edge until done.
- done  out  1  one-clk pulse when resp is valid.
- resp  out  RESP_W  captured response; held until next accepted start.
- link_clk  out  1  slave clock.
- link_cs  out  1  slave chip select.
- link_i  out  1  serial data to slave.
- link_o  in  1  serial data from slave.

Behaviour:
- Reset values: busy=0, done=0, resp=0, link_clk=0, link_cs=1, link_i=0. All state returns to IDLE, including mid-transaction.
- All outputs are registered.
- States: IDLE -> SEND -> LATCH -> RECV -> FIN -> IDLE.
- IDLE:
  - link_cs=1, link_clk=0.
  - start=1 captures key into the shift register, sets busy=1, enters SEND, and starts a link-bit period.
- Link-bit period:
  - link_clk is low for HALF_PERIOD clks, then high for HALF_PERIOD clks.
  - link_i and link_cs change only on the edge that starts the low phase.
- SEND:
  - KEY_W periods with link_cs=0.
  - Period j drives link_i=key[j], j=0..KEY_W-1.
- LATCH: one period with link_cs=1, link_i=0.
- RECV:
  - RESP_W periods with link_cs=0.
  - At the edge that raises link_clk, sample link_o and shift it into resp MSB: resp <= {link_o, resp[RESP_W-1:1]}.
  - The first sample therefore ends in resp[0].
  - resp shifts live during RECV.
- FIN:
  - Entered on the edge ending the last RECV period.
  - link_clk=0, link_cs=1, busy=0, done=1 for exactly one clk, then IDLE.
- Latency: the start-accept edge is T. done is high in the cycle after edge T + (KEY_W+1+RESP_W)*2*HALF_PERIOD. Default: T+578.
- Back-to-back: start may be asserted in the same cycle done=1; it is accepted, with no idle period inserted.
- start while busy is ignored; key is not resampled.
- Counters: bit counter sized for max(KEY_W, RESP_W). Phase counter sized for HALF_PERIOD. Wrap is never exposed.
- HALF_PERIOD=1: link_clk toggles every clk.

Optional Feature:
- Macro: CHAL_LINK_ABORT_EN.
- With macro:
  - Extra input port abort (1 bit).
  - abort=1 while busy returns the block to IDLE on the next edge: link_clk=0, link_cs=1, link_i=0, busy=0, resp cleared to 0, done not pulsed.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Without macro: no abort port; a transaction always runs to completion unless rst_n is asserted.

Test Plan:
- key=0x1337beef, HALF_PERIOD=1, behavioural slave returning a fixed 256-bit pattern 0xA5..A5 on o -> link_i sequence equals key LSB first over 32 periods; one cs-high period; resp=0xA5..A5; done pulses exactly once at T+578.
- Same stimulus with HALF_PERIOD=3 -> identical resp; link_clk high/low for 3 clks each; done at T+1734.
- start pulsed again mid-SEND with key=0 -> ignored; transmitted bits still 0x1337beef; single done.
- rst_n low during RECV bit 100 -> all outputs at reset values asynchronously; a new start afterwards completes normally with correct resp.
- Slave drives o = bit index parity (0,1,0,1...) -> resp = 0xAAAA...AAAA (resp[0]=0, resp[1]=1).
- With CHAL_LINK_ABORT_EN: abort during LATCH -> next clk busy=0, link_cs=1, resp=0, no done; a following transaction succeeds.

Source files
------------

// File: rtl/chal_link_master.sv
// Host-side bit-serial master for the challenge slave: shifts a key out LSB first, pulses cs to latch it,
// then captures the response LSB first. Define CHAL_LINK_ABORT_EN to add the abort input.
module chal_link_master #(
    parameter int KEY_W       = 32,
    parameter int RESP_W      = 256,
    parameter int HALF_PERIOD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
`ifdef CHAL_LINK_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic [RESP_W-1:0] resp,
    output logic              link_clk,
    output logic              link_cs,
    output logic              link_i,
    input  logic              link_o
);

    localparam int MAX_W = (KEY_W > RESP_W) ? KEY_W : RESP_W;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_W - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        LATCH,
        RECV,
        FIN
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [PH_W-1:0]    phase_reg, phase_next;
    logic [KEY_W-1:0]   shift_reg, shift_next;
    logic [RESP_W-1:0]  resp_reg, resp_next;
    logic               link_clk_reg, link_clk_next;
    logic               link_cs_reg, link_cs_next;
    logic               link_i_reg, link_i_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic               phase_end;
    logic               clk_rise;
    logic               period_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            phase_reg    <= '0;
            shift_reg    <= '0;
            resp_reg     <= '0;
            link_clk_reg <= 1'b0;
            link_cs_reg  <= 1'b1;
            link_i_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            phase_reg    <= phase_next;
            shift_reg    <= shift_next;
            resp_reg     <= resp_next;
            link_clk_reg <= link_clk_next;
            link_cs_reg  <= link_cs_next;
            link_i_reg   <= link_i_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        phase_next    = phase_reg;
        shift_next    = shift_reg;
        resp_next     = resp_reg;
        link_clk_next = link_clk_reg;
        link_cs_next  = link_cs_reg;
        link_i_next   = link_i_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        phase_end  = (phase_reg == PH_LAST);
        clk_rise   = phase_end && !link_clk_reg;
        period_end = phase_end && link_clk_reg;

        // Link clock runs low-then-high for every bit period while a transfer is active
        if (state_reg == SEND || state_reg == LATCH || state_reg == RECV) begin
            if (phase_end) begin
                phase_next    = '0;
                link_clk_next = ~link_clk_reg;
            end else begin
                phase_next = phase_reg + 1'b1;
            end
        end

        case (state_reg)
            IDLE, FIN: begin
                state_next    = IDLE;
                link_clk_next = 1'b0;
                link_cs_next  = 1'b1;
                link_i_next   = 1'b0;
                busy_next     = 1'b0;
                // FIN accepts start too, so a request arriving with done runs back-to-back
                if (start) begin
                    state_next   = SEND;
                    busy_next    = 1'b1;
                    link_cs_next = 1'b0;
                    link_i_next  = key[0];
                    shift_next   = key >> 1;
                    phase_next   = '0;
                    bit_cnt_next = '0;
                end
            end
            SEND: begin
                if (period_end) begin
                    if (bit_cnt_reg == KEY_LAST) begin
                        state_next   = LATCH;
                        link_cs_next = 1'b1;
                        link_i_next  = 1'b0;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        link_i_next  = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
            LATCH: begin
                if (period_end) begin
                    state_next   = RECV;
                    link_cs_next = 1'b0;
                    bit_cnt_next = '0;
                end
            end
            RECV: begin
                if (clk_rise) begin
                    resp_next = {link_o, resp_reg[RESP_W-1:1]};
                end
                if (period_end) begin
                    if (bit_cnt_reg == RESP_LAST) begin
                        state_next    = FIN;
                        link_clk_next = 1'b0;
                        link_cs_next  = 1'b1;
                        busy_next     = 1'b0;
                        done_next     = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef CHAL_LINK_ABORT_EN
        // busy is low in IDLE and FIN, so a coincident start always wins there
        if (abort && busy_reg) begin
            state_next    = IDLE;
            bit_cnt_next  = '0;
            phase_next    = '0;
            resp_next     = '0;
            link_clk_next = 1'b0;
            link_cs_next  = 1'b1;
            link_i_next   = 1'b0;
            busy_next     = 1'b0;
            done_next     = 1'b0;
        end
`endif
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign resp     = resp_reg;
    assign link_clk = link_clk_reg;
    assign link_cs  = link_cs_reg;
    assign link_i   = link_i_reg;

endmodule

// File: tb/tb_chal_link_master.sv
// Randomized scoreboard bench for chal_link_master with a behavioural challenge-slave model.
// Also exercises the abort input when CHAL_LINK_ABORT_EN is defined.
module tb_chal_link_master;

    localparam int KEY_W  = 32;
    localparam int RESP_W = 256;
    localparam int HP     = 3;
    localparam int LAT    = (KEY_W + 1 + RESP_W) * 2 * HP;

    typedef logic [RESP_W-1:0] wide_t;
    typedef struct {
        logic [KEY_W-1:0] k;
        wide_t            r;
        int               t;
    } txn_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [KEY_W-1:0] key   = '0;
`ifdef CHAL_LINK_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic             busy;
    logic             done;
    wide_t            resp;
    logic             link_clk;
    logic             link_cs;
    logic             link_i;
    logic             link_o = 1'b0;

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    txn_no      = 0;
    txn_t  sb[$];
    txn_t  e;
    wide_t pat       = '0;
    wide_t last_resp = '0;
    wide_t a5_pat    = '0;
    wide_t par_pat   = '0;

    logic [KEY_W-1:0] got_key = '0;
    int               nkey    = 0;
    int               ridx    = 0;
    bit               rmode   = 1'b0;

    int   run_len   = 0;
    bit   run_valid = 1'b0;
    logic lc_prev   = 1'b0;

    chal_link_master #(
        .KEY_W      (KEY_W),
        .RESP_W     (RESP_W),
        .HALF_PERIOD(HP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .key     (key),
`ifdef CHAL_LINK_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy),
        .done    (done),
        .resp    (resp),
        .link_clk(link_clk),
        .link_cs (link_cs),
        .link_i  (link_i),
        .link_o  (link_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Challenge slave: records key bits on rising link_clk, presents response bit n before the nth sampling edge
    always @(posedge busy or posedge link_clk) begin
        if (!link_clk) begin
            got_key = '0;
            nkey    = 0;
            rmode   = 1'b0;
            ridx    = 0;
        end else if (!rmode && !link_cs) begin
            if (nkey < KEY_W) got_key[nkey] = link_i;
            nkey++;
        end else if (!rmode && link_cs && nkey == KEY_W) begin
            rmode  = 1'b1;
            ridx   = 0;
            link_o = pat[0];
        end else if (rmode && !link_cs) begin
            ridx++;
            link_o = (ridx < RESP_W) ? pat[ridx] : 1'b0;
        end
    end

    task automatic chk(input string nm, input wide_t act, input wide_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: checks each completed transaction against the scoreboard and every link_clk half-period
    always @(negedge clk) begin
        if (!rst_n) begin
            run_valid = 1'b0;
            run_len   = 0;
            lc_prev   = link_clk;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: done=%b with no transaction outstanding", done);
                end else begin
                    e = sb.pop_front();
                    txn_no++;
                    chk("resp", resp, e.r);
                    chk("key_bits", wide_t'(got_key), wide_t'(e.k));
                    chk("key_count", wide_t'(nkey), wide_t'(KEY_W));
                    chk("latency", wide_t'(cyc - e.t), wide_t'(LAT));
                    last_resp = e.r;
                    $display("txn %0d key %h latency %0d resp[31:0] %h", txn_no, e.k, cyc - e.t, resp[31:0]);
                end
            end
            if (link_clk !== lc_prev) begin
                if (run_valid && (busy || done)) chk("half_period", wide_t'(run_len), wide_t'(HP));
                run_valid = busy;
                run_len   = 1;
                lc_prev   = link_clk;
            end else begin
                run_len++;
            end
        end
    end

    task automatic issue(input logic [KEY_W-1:0] k, input wide_t p);
        int w = 0;
        while (busy === 1'b1 && w < 2 * LAT) begin
            @(negedge clk);
            w++;
        end
        chk("issue_idle", wide_t'(busy), wide_t'(0));
        pat   = p;
        key   = k;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back('{k, p, cyc});
    endtask

    task automatic wait_done();
        int w = 0;
        while (done !== 1'b1 && w < LAT + 20) begin
            @(negedge clk);
            w++;
        end
        chk("done_seen", wide_t'(done), wide_t'(1));
    endtask

    function automatic wide_t rand_pat();
        wide_t p;
        for (int i = 0; i < RESP_W / 32; i++) p[i*32 +: 32] = $urandom();
        return p;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, wide_t'(busy), wide_t'(0));
        chk({tag, "_done"}, wide_t'(done), wide_t'(0));
        chk({tag, "_resp"}, resp, '0);
        chk({tag, "_link_clk"}, wide_t'(link_clk), wide_t'(0));
        chk({tag, "_link_cs"}, wide_t'(link_cs), wide_t'(1));
        chk({tag, "_link_i"}, wide_t'(link_i), wide_t'(0));
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        for (int i = 0; i < RESP_W / 8; i++) a5_pat[i*8 +: 8] = 8'hA5;
        for (int i = 0; i < RESP_W; i++) par_pat[i] = (i % 2 == 1);

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed key and A5 response
        issue(32'h1337beef, a5_pat);
        wait_done();
        @(negedge clk);

        // A second start during SEND must be ignored
        issue(32'h1337beef, a5_pat);
        repeat (20) @(negedge clk);
        key   = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // Asynchronous reset while receiving bit 100
        issue(32'h1337beef, rand_pat());
        w = 0;
        while (ridx < 100 && w < LAT) begin
            @(negedge clk);
            w++;
        end
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'h1337beef, a5_pat);
        wait_done();
        @(negedge clk);

        // Alternating response bits
        issue($urandom(), par_pat);
        wait_done();

        // Back-to-back: new start in the done cycle
        issue($urandom(), rand_pat());
        wait_done();
        issue($urandom(), rand_pat());
        wait_done();
        @(negedge clk);

        for (int n = 0; n < 3; n++) begin
            issue($urandom(), rand_pat());
            wait_done();
            repeat ($urandom_range(3, 0)) @(negedge clk);
            @(negedge clk);
        end

`ifdef CHAL_LINK_ABORT_EN
        // Abort during LATCH returns to idle with resp cleared and no done
        issue($urandom(), rand_pat());
        w = 0;
        while (!(busy && link_cs && nkey == KEY_W) && w < LAT) begin
            @(negedge clk);
            w++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", wide_t'(busy), wide_t'(0));
        chk("abort_link_cs", wide_t'(link_cs), wide_t'(1));
        chk("abort_link_clk", wide_t'(link_clk), wide_t'(0));
        chk("abort_resp", resp, '0);
        abort = 1'b0;
        sb.delete();
        repeat (10) @(negedge clk);
        chk("abort_no_done", wide_t'(txn_no), wide_t'(9));
        issue($urandom(), rand_pat());
        wait_done();
        @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        chk("resp_hold", resp, last_resp);
        chk("final_idle", wide_t'(busy), wide_t'(0));
        chk("sb_empty", wide_t'(sb.size()), wide_t'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
